// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Ports:
//   clock     in   system clock, all logic on its rising edge
//   reset     in   synchronous active-high reset
//   tx_data   in   [7:0] command byte, latched when tx_start is accepted
//   tx_start  in   request strobe, accepted only while busy=0
//   ps2c_in   in   asynchronous level of the PS/2 clock pin
//   ps2d_in   in   asynchronous level of the PS/2 data pin
//   ps2c_oe   out  1 = pull PS/2 clock low, 0 = release
//   ps2d_oe   out  1 = pull PS/2 data low, 0 = release
//   busy      out  high while a frame is in progress
//   tx_done   out  one-cycle pulse on an acknowledged transfer
//   tx_error  out  one-cycle pulse on timeout or missing ACK
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   // One counter serves both the inhibit interval and the timeout, so it
   // is sized for whichever limit is larger and can always reach it.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      XFER,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    bit_idx, bit_idx_n;
   logic [8:0]    frame, frame_n;      // {parity, data}, bit 0 sent first
   logic          drive, drive_n;      // value of ps2d_oe while in XFER
   logic          c_meta, c_sync, c_prev;
   logic          d_meta, d_sync;
   logic          fall;
   logic          timed_out;

   always_ff @(posedge clock) begin
      if (reset) begin
         c_meta  <= 1'b1;
         c_sync  <= 1'b1;
         c_prev  <= 1'b1;
         d_meta  <= 1'b1;
         d_sync  <= 1'b1;
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
         drive   <= 1'b0;
      end else begin
         c_meta  <= ps2c_in;
         c_sync  <= c_meta;
         c_prev  <= c_sync;
         d_meta  <= ps2d_in;
         d_sync  <= d_meta;
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         frame   <= frame_n;
         drive   <= drive_n;
      end
   end

   assign fall      = c_prev & ~c_sync;
   assign timed_out = (cnt == TO_LIM);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      frame_n   = frame;
      drive_n   = drive;
      ps2c_oe   = 1'b0;
      ps2d_oe   = 1'b0;
      tx_done   = 1'b0;
      tx_error  = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
            if (tx_start) begin
               frame_n   = {~^tx_data, tx_data};
               cnt_n     = '0;
               bit_idx_n = '0;
               drive_n   = 1'b0;
               state_n   = INHIBIT;
            end
         end

         INHIBIT: begin
            ps2c_oe = 1'b1;
            if (cnt == INH_LAST) begin
               // Start bit goes down one cycle before the clock is released.
               ps2d_oe = 1'b1;
               cnt_n   = '0;
               state_n = REQ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         REQ: begin
            ps2d_oe = 1'b1;
            if (timed_out) begin
               tx_error = 1'b1;
               cnt_n    = '0;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
               if (fall) begin
                  bit_idx_n = '0;
                  drive_n   = ~frame[0];
                  state_n   = XFER;
               end
            end
         end

         XFER: begin
            ps2d_oe = drive;
            if (timed_out) begin
               tx_error = 1'b1;
               cnt_n    = '0;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
               if (fall) begin
                  if (bit_idx == 4'd8) begin
                     // Parity has been clocked out; release for the stop bit.
                     drive_n = 1'b0;
                     state_n = ACK;
                  end else begin
                     bit_idx_n = bit_idx + 4'd1;
                     drive_n   = ~frame[bit_idx + 4'd1];
                  end
               end
            end
         end

         ACK: begin
            if (timed_out) begin
               tx_error = 1'b1;
               cnt_n    = '0;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
               if (fall) begin
                  if (!d_sync) begin
                     cnt_n   = '0;
                     state_n = WAIT_IDLE;
                  end else begin
                     tx_error = 1'b1;
                     state_n  = IDLE;
                  end
               end
            end
         end

         WAIT_IDLE: begin
            if (c_sync && d_sync) begin
               tx_done = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (timed_out) begin
               tx_error = 1'b1;
               cnt_n    = '0;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // An aborted frame must not report an outcome.
      if (reset) begin
         tx_done  = 1'b0;
         tx_error = 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

   localparam int INH      = 20;
   localparam int TO       = 400;
   localparam int DEV_HALF = 16;

   logic       CLOCK_50;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2c_in;
   logic       ps2d_in;
   logic       ps2c_oe;
   logic       ps2d_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   logic       dev_c_low;
   logic       dev_d_low;

   int n_cmp;
   int n_bad;
   int done_cnt;
   int err_cnt;
   int both_cnt;

   logic [9:0] sb_q[$];

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         poke;
      logic       par;
      int         done_n;
      int         err_n;
   } vec_t;

   vec_t vecs[5];

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock   (CLOCK_50),
      .reset   (reset),
      .tx_data (tx_data),
      .tx_start(tx_start),
      .ps2c_in (ps2c_in),
      .ps2d_in (ps2d_in),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe),
      .busy    (busy),
      .tx_done (tx_done),
      .tx_error(tx_error)
   );

   // Open-collector bus: either side can pull a line low.
   assign ps2c_in = ~(ps2c_oe | dev_c_low);
   assign ps2d_in = ~(ps2d_oe | dev_d_low);

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge CLOCK_50);
      tx_start = 1'b0;
   endtask

   // Device side: sees the start bit, then produces n_edges clock pulses,
   // sampling the data line late in each low phase. With ack set it pulls
   // data low ahead of the eleventh falling edge.
   task automatic dev_clock(input int n_edges, input bit ack,
                            output logic [9:0] bits, output logic start_bit);
      bits      = '0;
      start_bit = ps2d_in;
      repeat (10) @(negedge CLOCK_50);
      for (int e = 1; e <= n_edges; e++) begin
         dev_c_low = 1'b1;
         repeat (DEV_HALF) @(negedge CLOCK_50);
         if (e <= 10) bits[e-1] = ps2d_in;
         dev_c_low = 1'b0;
         if (e == 10 && ack) begin
            repeat (DEV_HALF / 2) @(negedge CLOCK_50);
            dev_d_low = 1'b1;
            repeat (DEV_HALF / 2) @(negedge CLOCK_50);
         end else begin
            repeat (DEV_HALF) @(negedge CLOCK_50);
         end
      end
      dev_d_low = 1'b0;
   endtask

   // Entered with the start already accepted (first INHIBIT cycle).
   task automatic run_frame(input vec_t v);
      int         inh;
      int         dpos;
      int         n;
      int         d0;
      int         e0;
      logic [9:0] bits;
      logic [9:0] exp;
      logic       sbit;
      sb_q.push_back({1'b1, v.par, v.data});
      d0 = done_cnt;
      e0 = err_cnt;
      check("busy_after_start", busy, 1);
      inh  = 0;
      dpos = -1;
      while (ps2c_oe && inh < 200) begin
         if (ps2d_oe && dpos < 0) dpos = inh;
         inh++;
         @(negedge CLOCK_50);
      end
      check("inhibit_len", inh, INH);
      check("data_low_in_last_inhibit", dpos, INH - 1);
      fork
         dev_clock(11, v.ack, bits, sbit);
         if (v.poke) begin
            repeat (120) @(negedge CLOCK_50);
            tx_data  = 8'hFF;
            tx_start = 1'b1;
            @(negedge CLOCK_50);
            tx_start = 1'b0;
         end
      join
      check("start_bit", sbit, 0);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame: got frame with empty scoreboard, required queued entry");
      end else begin
         exp = sb_q.pop_front();
         check("frame", bits, exp);
      end
      n = 0;
      while (busy && n < 500) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("busy_clear", busy, 0);
      check("done_pulses", done_cnt - d0, v.done_n);
      check("error_pulses", err_cnt - e0, v.err_n);
      check("lines_released", {ps2c_oe, ps2d_oe}, 0);
      n = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (ps2c_oe || busy) n++;
      end
      check("no_restart", n, 0);
   endtask

   initial begin
      int         n;
      int         d0;
      int         e0;
      logic [9:0] bits;
      logic       sbit;

      n_cmp     = 0;
      n_bad     = 0;
      done_cnt  = 0;
      err_cnt   = 0;
      both_cnt  = 0;
      dev_c_low = 1'b0;
      dev_d_low = 1'b0;
      tx_data   = 8'h00;
      tx_start  = 1'b0;
      reset     = 1'b1;

      vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1, 0};
      vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1, 0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1, 0};
      vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 1};
      vecs[4] = '{8'hF4, 1'b1, 1'b1, 1'b0, 1, 0};

      repeat (3) @(negedge CLOCK_50);
      check("reset_ps2c_oe", ps2c_oe, 0);
      check("reset_ps2d_oe", ps2d_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_pulses", {tx_done, tx_error}, 0);
      reset = 1'b0;
      repeat (5) @(negedge CLOCK_50);

      for (int i = 0; i < 5; i++) begin
         start_tx(vecs[i].data);
         run_frame(vecs[i]);
      end

      // Device never clocks: REQ times out.
      start_tx(8'h55);
      n = 0;
      while (ps2c_oe && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      e0 = err_cnt;
      n  = 0;
      while (!tx_error && n < 600) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("timeout_cycles", n, TO);
      @(negedge CLOCK_50);
      check("timeout_lines_released", {ps2c_oe, ps2d_oe}, 0);
      check("timeout_busy", busy, 0);
      check("timeout_error_pulses", err_cnt - e0, 1);
      repeat (10) @(negedge CLOCK_50);

      // Reset after the fifth device edge, then a start in the first free cycle.
      start_tx(8'hED);
      n = 0;
      while (ps2c_oe && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      dev_clock(5, 1'b0, bits, sbit);
      check("midframe_busy", busy, 1);
      d0    = done_cnt;
      e0    = err_cnt;
      reset = 1'b1;
      @(negedge CLOCK_50);
      check("midreset_ps2c_oe", ps2c_oe, 0);
      check("midreset_ps2d_oe", ps2d_oe, 0);
      check("midreset_busy", busy, 0);
      check("midreset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      reset = 1'b0;
      start_tx(8'hED);
      run_frame(vecs[0]);

      check("never_done_and_error", both_cnt, 0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
